regfile_2r1w: RTL
=================

Name: regfile_2r1w

Overview:
- Upstream neighbour of the N-bit ALU in the single-cycle datapath.
- Architectural register file: 2^AW registers of N bits each.
- Two combinational read ports drive the ALU A/B operands; one synchronous write port takes writeback (ALU result or memory data).
- r0 is hardwired to zero (MIPS convention); stack pointer and global pointer get preset reset values.

Parameters:
- N, 32, data width in bits (must match the ALU's N).
- AW, 5, register address width; depth = 2^AW.
- SP_IDX, 29, index of the stack-pointer register.
- SP_INIT, 32'h7FFF_EFFC, reset value of register SP_IDX (truncated/zero-extended to N).
- GP_IDX, 28, index of the global-pointer register.
- GP_INIT, 32'h1000_8000, reset value of register GP_IDX (truncated/zero-extended to N).

Ports:
- clk_i  in  1  system clock; rising edge active.
- rst_n_i  in  1  asynchronous active-low reset.
- ra_addr_i  in  AW  read port A address (rs).
- rb_addr_i  in  AW  read port B address (rt).
- ra_data_o  out  N  read port A data, to ALU A_i.
- rb_data_o  out  N  read port B data, to ALU B_i.
- we_i  in  1  write enable.
- wa_addr_i  in  AW  write address (rd/rt from decode).
- wd_data_i  in  N  write data (writeback mux output).
- wr_cnt_o  out  16  saturating count of committed writes, for debug/perf.

Behaviour:
- Reset: asserting rst_n_i low immediately, with no clock, sets:
  - every register to 0, except reg[SP_IDX] = SP_INIT and reg[GP_IDX] = GP_INIT;
  - wr_cnt_o = 0.
- Deassertion of reset is used synchronously by downstream logic; this block needs no extra synchroniser.
- Reset mid-write: reset wins. The write is discarded and the reset values hold.
- Write timing: on the rising edge of clk_i with rst_n_i = 1 and we_i = 1:
  - reg[wa_addr_i] <= wd_data_i, visible to reads in the following cycle;
  - if wa_addr_i == 0, storage is unchanged (r0 stays 0) and wr_cnt_o does not increment.
- Read timing: zero latency (combinational).
  - ra_data_o = (ra_addr_i == 0) ? 0 : reg[ra_addr_i]; rb_data_o likewise.
  - Ports A and B are fully independent. Identical addresses on both ports return identical data.
- Same-cycle write and read of the same address (without the optional feature): the read returns the OLD value; the new value appears after the edge.
- wr_cnt_o increments by 1 on each committed write to a nonzero address and saturates at 16'hFFFF with no wrap-around.
- SP_IDX and GP_IDX are ordinary writable registers after reset.
- If SP_IDX or GP_IDX is 0, r0 remains zero. The zero rule has priority over the init values.
- No X propagation: all addresses are in range by construction (depth = 2^AW).

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through bypass for split-phase writeback.
  - If we_i = 1, wa_addr_i != 0 and ra_addr_i == wa_addr_i, then ra_data_o = wd_data_i in the same cycle. Port B is handled the same way.
  - Storage and write timing are unchanged.
- Undefined: no bypass; reads always return stored contents as described above.

Test Plan:
- Reset values: pulse rst_n_i low asynchronously between edges, then read all 32 registers -> all 0 except r28 = 32'h1000_8000 and r29 = 32'h7FFF_EFFC; wr_cnt_o = 0.
- Write then read: write 32'hDEADBEEF to r5 and 32'h0000_0001 to r6 -> next cycle ra(5) = DEADBEEF, rb(6) = 00000001; wr_cnt_o = 2.
- r0 protection: write 32'hFFFFFFFF to r0 -> ra(0) = rb(0) = 0; wr_cnt_o unchanged.
- Same-cycle read/write: r7 = 32'h11, then write 32'h22 to r7 while reading r7 on both ports.
  - Without the macro: 32'h11 that cycle, 32'h22 the next.
  - With REGFILE_BYPASS_EN: 32'h22 immediately.
- Reset mid-operation: drop rst_n_i while we_i = 1 targeting r29 with 32'h1234 -> r29 = 32'h7FFF_EFFC; the write is lost.
- Counter saturation: force 65536 writes to r1 -> wr_cnt_o stops at 16'hFFFF; a further write leaves it at 16'hFFFF while r1 still updates.

Source files
------------

// File: rtl/regfile_2r1w_if.sv
// Bundle of read/write port signals for regfile_2r1w.
// The master (decode/writeback side) drives addresses and write data; the slave (the register file) returns read data and the write counter.
interface regfile_2r1w_if #(
  parameter int N  = 32,
  parameter int AW = 5
);
  // No handshake on this bus. Reads are combinational and always valid.
  // A write commits on the rising clock edge when we_i=1 and wa_addr_i!=0.
  logic [AW-1:0] ra_addr_i;
  logic [AW-1:0] rb_addr_i;
  logic [N-1:0]  ra_data_o;
  logic [N-1:0]  rb_data_o;
  logic          we_i;
  logic [AW-1:0] wa_addr_i;
  logic [N-1:0]  wd_data_i;
  logic [15:0]   wr_cnt_o;

  modport master (
    output ra_addr_i, rb_addr_i, we_i, wa_addr_i, wd_data_i,
    input  ra_data_o, rb_data_o, wr_cnt_o
  );

  modport slave (
    input  ra_addr_i, rb_addr_i, we_i, wa_addr_i, wd_data_i,
    output ra_data_o, rb_data_o, wr_cnt_o
  );
endinterface

// File: rtl/regfile_2r1w.sv
// 2-read/1-write register file: r0 reads as zero, and SP and GP have preset reset values.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module regfile_2r1w #(
  parameter int          N       = 32,
  parameter int          AW      = 5,
  parameter int          SP_IDX  = 29,
  parameter logic [31:0] SP_INIT = 32'h7FFF_EFFC,
  parameter int          GP_IDX  = 28,
  parameter logic [31:0] GP_INIT = 32'h1000_8000
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  regfile_2r1w_if.slave  rf
);

  localparam int          DEPTH  = 1 << AW;
  localparam logic [N-1:0] SP_RST = N'(SP_INIT);
  localparam logic [N-1:0] GP_RST = N'(GP_INIT);

  logic [N-1:0] regs_q [DEPTH];
  logic [15:0]  wr_cnt_q, wr_cnt_d;
  logic         wr_commit;
  logic [N-1:0] ra_data, rb_data;

  // The zero rule has priority over SP and GP, so r0 stays zero if either index is 0.
  function automatic logic [N-1:0] rst_val(input int idx);
    if (idx == 0)      return '0;
    if (idx == SP_IDX) return SP_RST;
    if (idx == GP_IDX) return GP_RST;
    return '0;
  endfunction

  always_comb begin
    wr_commit = rf.we_i && (rf.wa_addr_i != '0);
    wr_cnt_d  = wr_cnt_q;
    if (wr_commit && (wr_cnt_q != 16'hFFFF)) wr_cnt_d = wr_cnt_q + 16'd1;
  end

  // r0 is never written, so its reset value of zero holds permanently.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= rst_val(i);
    end else if (wr_commit) begin
      regs_q[rf.wa_addr_i] <= rf.wd_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) wr_cnt_q <= '0;
    else          wr_cnt_q <= wr_cnt_d;
  end

  always_comb begin
    ra_data = (rf.ra_addr_i == '0) ? '0 : regs_q[rf.ra_addr_i];
    rb_data = (rf.rb_addr_i == '0) ? '0 : regs_q[rf.rb_addr_i];
`ifdef REGFILE_BYPASS_EN
    if (wr_commit && (rf.ra_addr_i == rf.wa_addr_i)) ra_data = rf.wd_data_i;
    if (wr_commit && (rf.rb_addr_i == rf.wa_addr_i)) rb_data = rf.wd_data_i;
`else
    // Without bypass, a read in the write cycle returns the old contents.
`endif
  end

  assign rf.ra_data_o = ra_data;
  assign rf.rb_data_o = rb_data;
  assign rf.wr_cnt_o  = wr_cnt_q;

endmodule
